// File: rtl/digit_editor_if.sv
// digit_editor_if: edit controls in, digits and display state out
interface digit_editor_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W = 4
);
  localparam int CW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic edit_en;
  logic up;
  logic down;
  logic left;
  logic right;
  logic load_valid;
  logic [NUM_DIGITS*DIGIT_W-1:0] load_value;
  logic [NUM_DIGITS*DIGIT_W-1:0] value;
  logic [CW-1:0] cursor;
  logic [NUM_DIGITS-1:0] an_mask;
  logic editing;
  logic commit_valid;
  modport master (
    output edit_en, up, down, left, right, load_valid, load_value,
    input value, cursor, an_mask, editing, commit_valid
  );
  modport slave (
    input edit_en, up, down, left, right, load_valid, load_value,
    output value, cursor, an_mask, editing, commit_valid
  );
endinterface

// File: rtl/digit_editor.sv
// digit_editor: button-driven multi-digit value editor with blinking cursor
module digit_editor #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DIGIT_BASES = {4'd6, 4'd10, 4'd6, 4'd10},
  parameter int BLINK_DIV = 5_000_000,
  parameter bit CARRY_MODE = 1'b0,
  parameter bit CURSOR_WRAP = 1'b0
) (
  input logic clk,
  input logic rst,
  digit_editor_if.slave bus
);
  localparam int CW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] CNT_MAX = BW'(BLINK_DIV - 1);
  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;
  state_t state;
  logic [3:0] prev;
  logic [3:0] ev;
  logic inc;
  logic dec;
  logic carry;
  logic phase;
  logic editing_q;
  logic commit_q;
  logic [DIGIT_W-1:0] d;
  logic [DIGIT_W-1:0] b;
  logic [NUM_DIGITS*DIGIT_W-1:0] value_q;
  logic [NUM_DIGITS*DIGIT_W-1:0] stepped;
  logic [NUM_DIGITS*DIGIT_W-1:0] loaded;
  logic [CW-1:0] cursor_q;
  logic [CW-1:0] cursor_n;
  logic [BW-1:0] cnt;
  assign ev = {bus.right, bus.left, bus.down, bus.up} & ~prev;
  assign inc = ev[0] & ~ev[1];
  assign dec = ev[1] & ~ev[0];
  assign bus.value = value_q;
  assign bus.cursor = cursor_q;
  assign bus.editing = editing_q;
  assign bus.commit_valid = commit_q;
  // previous button levels; held high through reset so a held button is not an event
  always_ff @(posedge clk) begin
    prev <= rst ? '1 : {bus.right, bus.left, bus.down, bus.up};
  end
  // up/down applied at the cursor digit, rippling upward only while a digit wraps
  always_comb begin
    stepped = value_q;
    carry = 1'b0;
    d = '0;
    b = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = value_q[i*DIGIT_W +: DIGIT_W];
      b = DIGIT_BASES[i*DIGIT_W +: DIGIT_W];
      if (CW'(i) == cursor_q || (CARRY_MODE && carry)) begin
        stepped[i*DIGIT_W +: DIGIT_W] = inc ? (d == b - 1'b1 ? '0 : d + 1'b1) :
                                        dec ? (d == '0 ? b - 1'b1 : d - 1'b1) : d;
        carry = inc ? d == b - 1'b1 : dec && d == '0;
      end
    end
  end
  // out-of-range load digits are replaced by zero
  always_comb begin
    loaded = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      loaded[i*DIGIT_W +: DIGIT_W] = bus.load_value[i*DIGIT_W +: DIGIT_W] < DIGIT_BASES[i*DIGIT_W +: DIGIT_W] ?
                                     bus.load_value[i*DIGIT_W +: DIGIT_W] : '0;
  end
  // left moves toward the top digit, right toward digit 0
  always_comb begin
    cursor_n = (ev[2] & ~ev[3]) ? (cursor_q == TOP ? (CURSOR_WRAP ? '0 : TOP) : cursor_q + 1'b1) :
               (ev[3] & ~ev[2]) ? (cursor_q == '0 ? (CURSOR_WRAP ? TOP : '0) : cursor_q - 1'b1) : cursor_q;
  end
  // session FSM with digit, cursor and blink state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      value_q <= '0;
      cursor_q <= TOP;
      cnt <= '0;
      phase <= 1'b1;
      editing_q <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_valid) value_q <= loaded;
          if (bus.edit_en) begin
            state <= EDIT;
            editing_q <= 1'b1;
            cursor_q <= TOP;
            cnt <= '0;
            phase <= 1'b1;
          end
        end
        EDIT: begin
          value_q <= stepped;
          cursor_q <= cursor_n;
          cnt <= (cursor_n != cursor_q || cnt == CNT_MAX) ? '0 : cnt + 1'b1;
          phase <= cursor_n != cursor_q ? 1'b1 : cnt == CNT_MAX ? ~phase : phase;
          if (!bus.edit_en) begin
            state <= COMMIT;
            editing_q <= 1'b0;
            commit_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // selected digit blinks while editing, everything lit otherwise
  always_comb begin
    bus.an_mask = '1;
    if (editing_q) bus.an_mask[cursor_q] = phase;
  end
endmodule

// File: tb/tb_digit_editor.sv
// tb_digit_editor: two editor variants driven in lockstep against a mixed-radix model
module tb_digit_editor;
  localparam int BASE [4] = '{10, 6, 10, 6};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic edit_en = 1'b0;
  logic up = 1'b0;
  logic down = 1'b0;
  logic left = 1'b0;
  logic right = 1'b0;
  logic load_valid = 1'b0;
  logic [15:0] load_value = '0;
  int n_cmp = 0;
  int n_bad = 0;
  int md [2][4];
  int mc [2];
  int ms [2];
  int mt [2];
  logic [3:0] mprev = '1;
  logic [15:0] act_val [2];
  logic [1:0] act_cur [2];
  logic [3:0] act_mask [2];
  logic act_ed [2];
  logic act_cv [2];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    digit_editor_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus ();
    assign bus.edit_en = edit_en;
    assign bus.up = up;
    assign bus.down = down;
    assign bus.left = left;
    assign bus.right = right;
    assign bus.load_valid = load_valid;
    assign bus.load_value = load_value;
    assign act_val[g] = bus.value;
    assign act_cur[g] = bus.cursor;
    assign act_mask[g] = bus.an_mask;
    assign act_ed[g] = bus.editing;
    assign act_cv[g] = bus.commit_valid;
    digit_editor #(.BLINK_DIV(4), .CARRY_MODE(g == 1), .CURSOR_WRAP(g == 1)) dut (
      .clk(clk), .rst(rst), .bus(bus)
    );
  end
  // instance 0: independent digits, saturating cursor; instance 1: carrying, wrapping cursor
  task automatic bump(int m, int dir);
    int n;
    int w;
    if (m == 0) begin
      md[m][mc[m]] = (md[m][mc[m]] + dir + BASE[mc[m]]) % BASE[mc[m]];
    end else begin
      n = 0;
      w = 1;
      for (int i = mc[m]; i < 4; i++) begin
        n += md[m][i] * w;
        w *= BASE[i];
      end
      n = (n + dir + w) % w;
      for (int i = mc[m]; i < 4; i++) begin
        md[m][i] = n % BASE[i];
        n /= BASE[i];
      end
    end
  endtask
  task automatic model_step();
    logic [3:0] btn;
    logic [3:0] ev;
    int nc;
    int dg;
    btn = {right, left, down, up};
    ev = btn & ~mprev;
    mprev = btn;
    if (rst) begin
      mprev = '1;
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < 4; i++) md[m][i] = 0;
        mc[m] = 3;
        ms[m] = 0;
        mt[m] = 0;
      end
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (ms[m] == 0) begin
        if (load_valid)
          for (int i = 0; i < 4; i++) begin
            dg = int'((load_value >> (4 * i)) & 16'hf);
            md[m][i] = dg >= BASE[i] ? 0 : dg;
          end
        if (edit_en) begin
          ms[m] = 1;
          mc[m] = 3;
          mt[m] = 0;
        end
      end else if (ms[m] == 1) begin
        nc = mc[m];
        if (ev[0] != ev[1]) bump(m, ev[0] ? 1 : -1);
        if (ev[2] && !ev[3]) nc = mc[m] == 3 ? (m == 1 ? 0 : 3) : mc[m] + 1;
        if (ev[3] && !ev[2]) nc = mc[m] == 0 ? (m == 1 ? 3 : 0) : mc[m] - 1;
        mt[m] = nc != mc[m] ? 0 : mt[m] + 1;
        mc[m] = nc;
        if (!edit_en) ms[m] = 2;
      end else begin
        ms[m] = 0;
      end
    end
  endtask
  function automatic logic [15:0] mval(int m);
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'(md[m][i]);
    return v;
  endfunction
  function automatic logic [3:0] mmask(int m);
    logic [3:0] k;
    k = 4'hf;
    if (ms[m] == 1) k[mc[m]] = ((mt[m] / 4) % 2) == 0;
    return k;
  endfunction
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic press(int k);
    up = k == 0;
    down = k == 1;
    left = k == 2;
    right = k == 3;
    step();
    {up, down, left, right} = '0;
    step();
  endtask
  task automatic load(logic [15:0] v);
    load_valid = 1'b1;
    load_value = v;
    step();
    load_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    up = 1'b1;
    step();
    step();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (act_val[m] !== 16'h0) begin n_bad++; $display("FAIL reset_value[%0d]: got %h want %h", m, act_val[m], 16'h0); end
      n_cmp++; if (act_cur[m] !== 2'd3) begin n_bad++; $display("FAIL reset_cursor[%0d]: got %0d want 3", m, act_cur[m]); end
      n_cmp++; if (act_mask[m] !== 4'hf) begin n_bad++; $display("FAIL reset_mask[%0d]: got %h want f", m, act_mask[m]); end
      n_cmp++; if (act_ed[m] !== 1'b0 || act_cv[m] !== 1'b0) begin n_bad++; $display("FAIL reset_flags[%0d]: got ed=%b cv=%b want 0 0", m, act_ed[m], act_cv[m]); end
    end
    rst = 1'b0;
    up = 1'b0;
    step();
  endtask
  task automatic test_load();
    load(16'hA7F3);
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (act_val[m] !== 16'h0703) begin n_bad++; $display("FAIL load_sanitize[%0d]: got %h want 0703", m, act_val[m]); end
    end
    load(16'h5959);
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (act_val[m] !== 16'h5959) begin n_bad++; $display("FAIL load_plain[%0d]: got %h want 5959", m, act_val[m]); end
    end
  endtask
  task automatic test_edit_down();
    edit_en = 1'b1;
    step();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (act_ed[m] !== 1'b1 || act_cur[m] !== 2'd3) begin n_bad++; $display("FAIL edit_entry[%0d]: got ed=%b cur=%0d want 1 3", m, act_ed[m], act_cur[m]); end
    end
    load(16'h0000);
    press(1);
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (act_val[m] !== 16'h4959) begin n_bad++; $display("FAIL edit_down[%0d]: got %h want 4959", m, act_val[m]); end
    end
    edit_en = 1'b0;
    step();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (act_cv[m] !== 1'b1 || act_ed[m] !== 1'b0) begin n_bad++; $display("FAIL commit_pulse[%0d]: got cv=%b ed=%b want 1 0", m, act_cv[m], act_ed[m]); end
    end
    step();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (act_cv[m] !== 1'b0 || act_val[m] !== 16'h4959) begin n_bad++; $display("FAIL commit_end[%0d]: got cv=%b val=%h want 0 4959", m, act_cv[m], act_val[m]); end
    end
  endtask
  task automatic test_carry();
    logic [15:0] want;
    load(16'h0959);
    edit_en = 1'b1;
    step();
    for (int i = 0; i < 3; i++) press(3);
    press(0);
    for (int m = 0; m < 2; m++) begin
      want = m == 1 ? 16'h1000 : 16'h0950;
      n_cmp++; if (act_cur[m] !== 2'd0 || act_val[m] !== want) begin n_bad++; $display("FAIL carry_up[%0d]: got cur=%0d val=%h want 0 %h", m, act_cur[m], act_val[m], want); end
    end
    press(1);
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (act_val[m] !== 16'h0959) begin n_bad++; $display("FAIL borrow_down[%0d]: got %h want 0959", m, act_val[m]); end
    end
    edit_en = 1'b0;
    step();
    step();
  endtask
  task automatic test_wrap();
    logic [15:0] want;
    load(16'h0009);
    edit_en = 1'b1;
    step();
    for (int i = 0; i < 3; i++) press(3);
    press(0);
    for (int m = 0; m < 2; m++) begin
      want = m == 1 ? 16'h0010 : 16'h0000;
      n_cmp++; if (act_val[m] !== want) begin n_bad++; $display("FAIL digit_wrap[%0d]: got %h want %h", m, act_val[m], want); end
    end
    for (int i = 0; i < 3; i++) press(2);
    press(2);
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (act_cur[m] !== (m == 1 ? 2'd0 : 2'd3)) begin n_bad++; $display("FAIL cursor_end[%0d]: got %0d want %0d", m, act_cur[m], m == 1 ? 0 : 3); end
    end
    edit_en = 1'b0;
    step();
    step();
  endtask
  task automatic test_simultaneous();
    load(16'h1234);
    edit_en = 1'b1;
    step();
    up = 1'b1;
    down = 1'b1;
    step();
    {up, down} = '0;
    left = 1'b1;
    right = 1'b1;
    step();
    {left, right} = '0;
    step();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (act_val[m] !== 16'h1234 || act_cur[m] !== 2'd3) begin n_bad++; $display("FAIL both_pressed[%0d]: got val=%h cur=%0d want 1234 3", m, act_val[m], act_cur[m]); end
    end
    up = 1'b1;
    right = 1'b1;
    step();
    {up, right} = '0;
    step();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (act_val[m] !== 16'h2234 || act_cur[m] !== 2'd2) begin n_bad++; $display("FAIL digit_and_move[%0d]: got val=%h cur=%0d want 2234 2", m, act_val[m], act_cur[m]); end
    end
    edit_en = 1'b0;
    step();
    step();
  endtask
  task automatic test_blink();
    logic [3:0] want;
    edit_en = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      want = ((k / 4) % 2) == 0 ? 4'hf : 4'h7;
      for (int m = 0; m < 2; m++) begin
        n_cmp++; if (act_mask[m] !== want) begin n_bad++; $display("FAIL blink_t%0d[%0d]: got %h want %h", k, m, act_mask[m], want); end
      end
      step();
    end
    step();
    step();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (act_mask[m] !== 4'h7) begin n_bad++; $display("FAIL blink_dark[%0d]: got %h want 7", m, act_mask[m]); end
    end
    right = 1'b1;
    step();
    right = 1'b0;
    for (int k = 0; k < 5; k++) begin
      want = k < 4 ? 4'hf : 4'hb;
      for (int m = 0; m < 2; m++) begin
        n_cmp++; if (act_mask[m] !== want || act_cur[m] !== 2'd2) begin n_bad++; $display("FAIL blink_restart_t%0d[%0d]: got mask=%h cur=%0d want %h 2", k, m, act_mask[m], act_cur[m], want); end
      end
      step();
    end
    edit_en = 1'b0;
    step();
    step();
  endtask
  task automatic test_commit_event();
    load(16'h2234);
    edit_en = 1'b1;
    step();
    down = 1'b1;
    edit_en = 1'b0;
    step();
    down = 1'b0;
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (act_val[m] !== 16'h1234 || act_cv[m] !== 1'b1) begin n_bad++; $display("FAIL event_at_commit[%0d]: got val=%h cv=%b want 1234 1", m, act_val[m], act_cv[m]); end
    end
    step();
  endtask
  task automatic test_rst_abort();
    edit_en = 1'b1;
    step();
    up = 1'b1;
    step();
    rst = 1'b1;
    step();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (act_val[m] !== 16'h0 || act_ed[m] !== 1'b0 || act_cv[m] !== 1'b0 || act_cur[m] !== 2'd3) begin n_bad++; $display("FAIL rst_abort[%0d]: got val=%h ed=%b cv=%b cur=%0d want 0000 0 0 3", m, act_val[m], act_ed[m], act_cv[m], act_cur[m]); end
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        n_cmp++; if (act_val[m] !== 16'h0 || act_cv[m] !== 1'b0) begin n_bad++; $display("FAIL held_after_rst_t%0d[%0d]: got val=%h cv=%b want 0000 0", k, m, act_val[m], act_cv[m]); end
      end
    end
    up = 1'b0;
    step();
    press(0);
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (act_val[m] !== 16'h1000) begin n_bad++; $display("FAIL repress_after_rst[%0d]: got %h want 1000", m, act_val[m]); end
    end
    edit_en = 1'b0;
    step();
    step();
  endtask
  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, 15) == 0) edit_en = ~edit_en;
      up = $urandom_range(0, 3) == 0;
      down = $urandom_range(0, 3) == 0;
      left = $urandom_range(0, 3) == 0;
      right = $urandom_range(0, 3) == 0;
      load_valid = $urandom_range(0, 7) == 0;
      load_value = 16'($urandom);
      step();
      for (int m = 0; m < 2; m++) begin
        n_cmp++; if (act_val[m] !== mval(m)) begin n_bad++; $display("FAIL rand_value c%0d[%0d]: got %h want %h", c, m, act_val[m], mval(m)); end
        n_cmp++; if (act_cur[m] !== 2'(mc[m])) begin n_bad++; $display("FAIL rand_cursor c%0d[%0d]: got %0d want %0d", c, m, act_cur[m], mc[m]); end
        n_cmp++; if (act_mask[m] !== mmask(m)) begin n_bad++; $display("FAIL rand_mask c%0d[%0d]: got %h want %h", c, m, act_mask[m], mmask(m)); end
        n_cmp++; if (act_ed[m] !== (ms[m] == 1) || act_cv[m] !== (ms[m] == 2)) begin n_bad++; $display("FAIL rand_flags c%0d[%0d]: got ed=%b cv=%b want %b %b", c, m, act_ed[m], act_cv[m], ms[m] == 1, ms[m] == 2); end
      end
    end
    rst = 1'b0;
    {up, down, left, right, load_valid, edit_en} = '0;
    step();
  endtask
  initial begin
    test_reset();
    test_load();
    test_edit_down();
    test_carry();
    test_wrap();
    test_simultaneous();
    test_blink();
    test_commit_event();
    test_rst_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/digit_editor.md
DIGIT_EDITOR -- requirements
Module: digit_editor

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of BCD-style digits edited.
REQ-002 SHALL have parameter DIGIT_W, default 4, bits per digit.
REQ-003 SHALL have parameter DIGIT_BASES, default {4'd6,4'd10,4'd6,4'd10}, packed NUM_DIGITS*DIGIT_W vector; digit i modulus is slice i, with digit 0 at the LSBs.
REQ-004 SHALL have parameter BLINK_DIV, default 5_000_000, clock cycles per blink half-period.
REQ-005 SHALL have parameter CARRY_MODE, default 0: 0 = each digit wraps independently; 1 = carry/borrow ripples to higher digits.
REQ-006 SHALL have parameter CURSOR_WRAP, default 0: 0 = cursor saturates at ends; 1 = cursor wraps.
REQ-007 clk  input  1  clock; all state on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 edit_en  input  1  level; high = edit mode requested.
REQ-010 up, down, left, right  input  1 each  level button inputs, rising-edge detected internally.
REQ-011 load_valid  input  1  load request.
REQ-012 load_value  input  NUM_DIGITS*DIGIT_W  value to load.
REQ-013 value  output  NUM_DIGITS*DIGIT_W  current digits, registered.
REQ-014 cursor  output  $clog2(NUM_DIGITS)  selected digit index.
REQ-015 an_mask  output  NUM_DIGITS  per-digit visibility, 1 = lit.
REQ-016 editing  output  1  high in EDIT state.
REQ-017 commit_valid  output  1  one-cycle pulse when an edit session ends.

Function
REQ-018 Button event SHALL be in & ~prev, with prev a registered copy of the input; prev registers reset to 1 so buttons held through reset yield no event.
REQ-019 FSM states SHALL be IDLE, EDIT and COMMIT.
REQ-020 IDLE->EDIT on edit_en=1; on entry cursor=NUM_DIGITS-1 and blink counter/phase cleared.
REQ-021 EDIT->COMMIT on edit_en=0; COMMIT lasts exactly one cycle with commit_valid=1, then IDLE.
REQ-022 In IDLE, load_valid=1 SHALL capture load_value the next edge; any digit >= its base SHALL be stored as 0. load_valid SHALL be ignored in EDIT and COMMIT.
REQ-023 Button events SHALL be ignored outside EDIT.
REQ-024 In EDIT, up event: digit[cursor]+1 mod base; down event: digit[cursor]-1 mod base (0 -> base-1); the update is visible after the sampling edge.
REQ-025 CARRY_MODE=1: wrap of digit i on up increments digit i+1, recursively; borrow symmetric on down; top-digit wrap discards the carry. All digits SHALL update in the same edge.
REQ-026 Carry SHALL propagate only to digits above cursor; lower digits are unchanged.
REQ-027 left event: cursor+1; right event: cursor-1. At ends, saturate (CURSOR_WRAP=0) or wrap (CURSOR_WRAP=1).
REQ-028 Simultaneous up+down SHALL leave value unchanged; simultaneous left+right SHALL leave cursor unchanged.
REQ-029 Digit and cursor events in the same cycle SHALL both apply, with the digit op using the pre-move cursor.
REQ-030 Blink phase SHALL toggle every BLINK_DIV cycles in EDIT; counter and phase (phase=1, lit) SHALL reset on every cursor change.
REQ-031 an_mask SHALL be all ones in IDLE/COMMIT; in EDIT, all ones except bit[cursor]=phase.
REQ-032 edit_en dropping and a button event in the same cycle: the event SHALL be applied and COMMIT entered.

Reset
REQ-033 rst SHALL set value=0, cursor=NUM_DIGITS-1, state=IDLE, editing=0, commit_valid=0, an_mask=all ones, blink counter=0, phase=1, prev=1.
REQ-034 rst SHALL take priority over all inputs, including mid-session; no commit_valid pulse on reset abort.

Verification
REQ-035 Defaults, IDLE load 0x5959, edit_en=1, cursor at 3, 1 down press -> value 0x4959; drop edit_en -> single commit_valid pulse, value held.
REQ-036 CARRY_MODE=1, value 0x0959, cursor moved to 0 (3 right presses), 1 up -> 0x1000; 1 down -> 0x0959.
REQ-037 CARRY_MODE=0, value 0x0009, cursor 0, up -> 0x0000; cursor 3, left press -> cursor stays 3 (CURSOR_WRAP=0), 0 with CURSOR_WRAP=1.
REQ-038 up+down asserted same cycle -> value unchanged; left+right same cycle -> cursor unchanged.
REQ-039 BLINK_DIV=4: in EDIT, an_mask[cursor] toggles every 4 cycles, other bits 1; cursor move -> bit lit immediately, counter restarted.
REQ-040 load_value 0xA7F3 in IDLE -> value 0x0703; rst asserted mid-edit with up held -> value 0, IDLE, no commit_valid, no event after rst release until up re-pressed.
